// File: rtl/button_gate_pkg.sv
// Shared types and gate evaluation for the N-button logic gate demo.
package button_gate_pkg;

  typedef enum logic [1:0] {
    MODE_AND  = 2'd0,
    MODE_OR   = 2'd1,
    MODE_XOR  = 2'd2,
    MODE_XNOR = 2'd3
  } mode_e;

  localparam mode_e MODE_RESET = MODE_XOR;
  localparam int    GATE_MAX   = 32;

  // Only the low n bits of a take part; n is a static parameter at every call site.
  function automatic logic gate_eval(input logic [GATE_MAX-1:0] a, input int n, input mode_e m);
    logic r_and, r_or, r_xor, r;
    r_and = 1'b1;
    r_or  = 1'b0;
    r_xor = 1'b0;
    for (int i = 0; i < GATE_MAX; i++) begin
      if (i < n) begin
        r_and &= a[i];
        r_or  |= a[i];
        r_xor ^= a[i];
      end
    end
    case (m)
      MODE_AND: r = r_and;
      MODE_OR:  r = r_or;
      MODE_XOR: r = r_xor;
      default:  r = ~r_xor;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus consecutive-sample debouncer for one active-low button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic level,
  output logic rise
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             synced, differ, accept;

  assign synced = ~sync2_q;
  assign differ = synced != state_q;
  assign accept = differ && (cnt_q == CNT_LAST);

  // Any matching sample drops the count, so only unbroken runs can flip the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (differ) begin
      if (accept) state_d = ~state_q;
      else        cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_n;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = state_q;
  // Press accepted on this edge: state is about to go 0 -> 1.
  assign rise  = accept & synced;

endmodule

// File: rtl/button_gate_n.sv
// N debounced active-low buttons into a mode-selectable gate; result and mode on active-low LEDs.
module button_gate_n
  import button_gate_pkg::*;
#(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_n,
  input  logic             btn_mode_n,
  output logic             led_r,
  output logic             led_g,
  output logic             led_b,
  output logic             q_o,
  output logic [1:0]       mode_o
);

  logic [N_BTN:0] raw_n, lvl, rise;

  // Index N_BTN is the mode button; it shares the same debounce path.
  assign raw_n = {btn_mode_n, btn_n};

  for (genvar i = 0; i <= N_BTN; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .raw_n(raw_n[i]),
      .level(lvl[i]),
      .rise (rise[i])
    );
  end

  logic unused_sig;
  assign unused_sig = ^{rise[N_BTN-1:0], lvl[N_BTN]};

  mode_e               mode_q, mode_d;
  logic                q_q, q_d;
  logic                led_r_q, led_g_q, led_b_q;
  logic [GATE_MAX-1:0] gate_vec;

  assign gate_vec = GATE_MAX'(lvl[N_BTN-1:0]);

  always_comb begin
    mode_d = rise[N_BTN] ? mode_e'(mode_q + 2'd1) : mode_q;
    q_d    = gate_eval(gate_vec, N_BTN, mode_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= MODE_RESET;
      q_q     <= 1'b0;
      led_r_q <= 1'b1;
      led_g_q <= 1'b1;
      led_b_q <= 1'b1;
    end else begin
      mode_q  <= mode_d;
      q_q     <= q_d;
      led_r_q <= ~q_d;
      led_g_q <= ~mode_q[0];
      led_b_q <= ~mode_q[1];
    end
  end

  assign q_o    = q_q;
  assign led_r  = led_r_q;
  assign led_g  = led_g_q;
  assign led_b  = led_b_q;
  assign mode_o = mode_q;

endmodule

// File: tb/tb_button_gate_n.sv
// Random and directed stimulus against a sample-window reference model of the button gate.
module tb_button_gate_n;

  localparam int N  = 2;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         rst, btn_mode_n;
  logic [N-1:0] btn_n;
  logic         led_r, led_g, led_b, q_o;
  logic [1:0]   mode_o;

  always #5 clk = ~clk;

  button_gate_n #(.N_BTN(N), .DEBOUNCE_CYCLES(DC)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_n     (btn_n),
    .btn_mode_n(btn_mode_n),
    .led_r     (led_r),
    .led_g     (led_g),
    .led_b     (led_b),
    .q_o       (q_o),
    .mode_o    (mode_o)
  );

  int total = 0;
  int bad   = 0;

  // Model: raw samples per input (bit 0 = newest); a level is accepted once the
  // DC samples seen through the 2-stage sync all disagree with the held state.
  logic [15:0] hist [N+1];
  logic        st   [N+1];
  int          m_mode;
  logic        m_q, m_lr, m_lg, m_lb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [N:0] raw;
    int ones;
    raw = {btn_mode_n, btn_n};
    if (rst) begin
      for (int k = 0; k <= N; k++) begin
        hist[k] = '1;
        st[k]   = 1'b0;
      end
      m_mode = 2;
      m_q = 1'b0; m_lr = 1'b1; m_lg = 1'b1; m_lb = 1'b1;
    end else begin
      ones = 0;
      for (int k = 0; k < N; k++) ones += int'(st[k]);
      case (m_mode)
        0:       m_q = (ones == N);
        1:       m_q = (ones > 0);
        2:       m_q = (ones % 2) == 1;
        default: m_q = (ones % 2) == 0;
      endcase
      m_lr = !m_q;
      m_lg = (m_mode % 2) == 0;
      m_lb = (m_mode / 2) == 0;
      for (int k = 0; k <= N; k++) begin
        if (hist[k][DC:1] == {DC{st[k]}}) begin
          st[k] = !st[k];
          if (k == N && st[k]) m_mode = (m_mode + 1) % 4;
        end
      end
      for (int k = 0; k <= N; k++) hist[k] = {hist[k][14:0], raw[k]};
    end
  endtask

  task automatic tick(input logic r, input logic [N-1:0] b, input logic mb);
    rst = r; btn_n = b; btn_mode_n = mb;
    @(posedge clk);
    model_step();
    #1;
    chk("q_o",    q_o,    m_q);
    chk("led_r",  led_r,  m_lr);
    chk("led_g",  led_g,  m_lg);
    chk("led_b",  led_b,  m_lb);
    chk("mode_o", mode_o, m_mode);
  endtask

  task automatic hold(input int n);
    repeat (n) tick(rst, btn_n, btn_mode_n);
  endtask

  task automatic lat_to(input logic want, output int n);
    n = 0;
    do begin
      tick(rst, btn_n, btn_mode_n);
      n++;
    end while (q_o !== want && n < 30);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  int n;
  logic seen;
  int em [4] = '{3, 0, 1, 2};
  int eq [4] = '{1, 1, 1, 0};
  int bl [6] = '{0, 1, 0, 1, 0, 1};
  int bn [6] = '{2, 2, 50, 2, 2, 20};

  initial begin
    rst = 1'b1; btn_n = '1; btn_mode_n = 1'b1;
    repeat (3) tick(1'b1, '1, 1'b1);
    chk("rst_q", q_o, 0);
    chk("rst_led_r", led_r, 1);
    chk("rst_led_b", led_b, 1);
    tick(1'b0, '1, 1'b1);
    chk("post_mode", mode_o, 2);
    chk("post_led_b", led_b, 0);
    chk("post_led_g", led_g, 1);
    chk("post_led_r", led_r, 1);
    hold(10);

    // XOR latency for one press, then for the second button.
    btn_n = 2'b10;
    lat_to(1'b1, n);
    chk("lat_press", n, 7);
    hold(3);
    btn_n = 2'b00;
    lat_to(1'b0, n);
    chk("lat_both", n, 7);

    // Glitches: 3 samples rejected, 4 accepted.
    btn_n = '1; hold(12);
    seen = 1'b0;
    repeat (3)  begin tick(1'b0, 2'b10, 1'b1); seen |= q_o; end
    repeat (12) begin tick(1'b0, 2'b11, 1'b1); seen |= q_o; end
    chk("glitch3", seen, 0);
    seen = 1'b0;
    repeat (4)  begin tick(1'b0, 2'b10, 1'b1); seen |= q_o; end
    repeat (12) begin tick(1'b0, 2'b11, 1'b1); seen |= q_o; end
    chk("pulse4", seen, 1);

    // Mode cycle with both buttons pressed.
    btn_n = 2'b00; hold(10);
    for (int p = 0; p < 4; p++) begin
      btn_mode_n = 1'b0; hold(10);
      btn_mode_n = 1'b1; hold(10);
      chk("cyc_mode", mode_o, em[p]);
      chk("cyc_q", q_o, eq[p]);
      chk("cyc_led_g", led_g, (em[p] % 2) == 0);
      chk("cyc_led_b", led_b, (em[p] / 2) == 0);
    end

    // Long hold with bounces at both ends advances once.
    for (int s = 0; s < 6; s++) begin
      btn_mode_n = bl[s][0];
      hold(bn[s]);
    end
    chk("bounce_mode", mode_o, 3);

    // Reach mode 1, then reset during a partial count on btn 1.
    repeat (2) begin
      btn_mode_n = 1'b0; hold(10);
      btn_mode_n = 1'b1; hold(10);
    end
    chk("pre_rst_mode", mode_o, 1);
    btn_n = '1; hold(10);
    btn_n = 2'b01; hold(4);
    rst = 1'b1; hold(2);
    rst = 1'b0;
    lat_to(1'b1, n);
    chk("lat_rst", n, 7);
    chk("rst_mid_mode", mode_o, 2);

    // Random phase.
    for (int s = 0; s < 500; s++) begin
      logic         r, mb;
      logic [N-1:0] b;
      int           len;
      r   = ($urandom_range(0, 40) == 0);
      b   = N'($urandom);
      mb  = ($urandom_range(0, 2) == 0);
      len = r ? $urandom_range(1, 2) : $urandom_range(1, 9);
      repeat (len) tick(r, b, mb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
